// File: rtl/register_read_stage.sv
// -----------------------------------------------------------------------------
// register_read_stage
//
// Reads operands for an issued bundle of up to WIDTH micro-ops. It sends two
// physical register file read requests per lane. Data being written back in the
// same cycle overrides the file output, because the file only updates at the
// clock edge. The resolved operands are held in a one-entry output register
// that feeds execute.
//
// Ports
//   clk_in, rst_in        clock (rising edge) / asynchronous active-low reset
//   flush_in              squash the held bundle and drop the incoming one
//   in_valid / in_ready   issue-side handshake (in_ready = !out_valid || out_ready)
//   in_lane_valid         per-lane occupancy mask, passed through unchanged
//   in_src0 / in_src1     per-lane source physical register indices
//   in_tag                opaque per-lane payload, passed through
//   rf_rd0/1_addr         read requests to the file (copies of in_src0/1)
//   rf_rd0/1_data         file read responses (combinational, same cycle)
//   wb_en/addr/data       writeback ports, the same signals the file sees
//   out_valid / out_ready execute-side handshake
//   out_lane_valid        registered lane mask
//   out_op0 / out_op1     resolved operands
//   out_tag               registered payload
// -----------------------------------------------------------------------------
module register_read_stage #(
    parameter int WIDTH      = 2,
    parameter int PREG_BITS  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          flush_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_lane_valid,
    input  logic [WIDTH*PREG_BITS-1:0]    in_src0,
    input  logic [WIDTH*PREG_BITS-1:0]    in_src1,
    input  logic [WIDTH*TAG_WIDTH-1:0]    in_tag,
    output logic [WIDTH*PREG_BITS-1:0]    rf_rd0_addr,
    output logic [WIDTH*PREG_BITS-1:0]    rf_rd1_addr,
    input  logic [WIDTH*DATA_WIDTH-1:0]   rf_rd0_data,
    input  logic [WIDTH*DATA_WIDTH-1:0]   rf_rd1_data,
    input  logic [WIDTH-1:0]              wb_en,
    input  logic [WIDTH*PREG_BITS-1:0]    wb_addr,
    input  logic [WIDTH*DATA_WIDTH-1:0]   wb_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_lane_valid,
    output logic [WIDTH*DATA_WIDTH-1:0]   out_op0,
    output logic [WIDTH*DATA_WIDTH-1:0]   out_op1,
    output logic [WIDTH*TAG_WIDTH-1:0]    out_tag
);

    logic                        out_valid_reg;
    logic [WIDTH-1:0]            out_lane_valid_reg;
    logic [WIDTH*DATA_WIDTH-1:0] out_op0_reg;
    logic [WIDTH*DATA_WIDTH-1:0] out_op1_reg;
    logic [WIDTH*TAG_WIDTH-1:0]  out_tag_reg;

    logic [WIDTH*DATA_WIDTH-1:0] op0_next;
    logic [WIDTH*DATA_WIDTH-1:0] op1_next;
    logic                        accept;

    // Resolve one operand. Register 0 always reads as zero. Otherwise the
    // lowest-index matching writeback lane wins over the stale file data.
    // Scanning from the top lane down lets the lowest lane overwrite last.
    function automatic logic [DATA_WIDTH-1:0] resolve_operand(
        input logic [PREG_BITS-1:0]        src,
        input logic [DATA_WIDTH-1:0]       file_data,
        input logic [WIDTH-1:0]            en,
        input logic [WIDTH*PREG_BITS-1:0]  addr,
        input logic [WIDTH*DATA_WIDTH-1:0] data
    );
        logic [DATA_WIDTH-1:0] result;
        result = file_data;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (en[k] && (addr[k*PREG_BITS +: PREG_BITS] == src)) begin
                result = data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (src == '0) begin
            result = '0;
        end
        return result;
    endfunction

    // The read addresses are forwarded every cycle, whether or not in_valid is set.
    assign rf_rd0_addr = in_src0;
    assign rf_rd1_addr = in_src1;

    // There is no skid buffer, so a held bundle blocks issue until execute takes it.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready && !flush_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign op0_next[gi*DATA_WIDTH +: DATA_WIDTH] = resolve_operand(
                in_src0[gi*PREG_BITS +: PREG_BITS],
                rf_rd0_data[gi*DATA_WIDTH +: DATA_WIDTH],
                wb_en, wb_addr, wb_data);
            assign op1_next[gi*DATA_WIDTH +: DATA_WIDTH] = resolve_operand(
                in_src1[gi*PREG_BITS +: PREG_BITS],
                rf_rd1_data[gi*DATA_WIDTH +: DATA_WIDTH],
                wb_en, wb_addr, wb_data);
        end
    endgenerate

    // Operands are captured only on accept. A held bundle is never re-resolved,
    // so later writebacks cannot disturb it. A flush clears the valids but
    // leaves the stale payload in place, because nothing downstream reads it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_valid_reg      <= 1'b0;
            out_lane_valid_reg <= '0;
            out_op0_reg        <= '0;
            out_op1_reg        <= '0;
            out_tag_reg        <= '0;
        end else if (flush_in) begin
            out_valid_reg      <= 1'b0;
            out_lane_valid_reg <= '0;
        end else if (accept) begin
            out_valid_reg      <= 1'b1;
            out_lane_valid_reg <= in_lane_valid;
            out_op0_reg        <= op0_next;
            out_op1_reg        <= op1_next;
            out_tag_reg        <= in_tag;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg      <= 1'b0;
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_lane_valid = out_lane_valid_reg;
    assign out_op0        = out_op0_reg;
    assign out_op1        = out_op1_reg;
    assign out_tag        = out_tag_reg;

endmodule

// File: tb/tb_register_read_stage.sv
// -----------------------------------------------------------------------------
// tb_register_read_stage
//
// Self-checking bench for register_read_stage. A behavioural physical register
// file answers the read ports and absorbs writebacks after each edge. The bench
// keeps a reference model that holds the one-entry output bundle. It computes
// each operand as "zero register, else first matching writeback, else file
// contents". Directed cases are run first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_register_read_stage;

    localparam int WIDTH      = 2;
    localparam int PREG_BITS  = 6;
    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 8;
    localparam int NREGS      = 1 << PREG_BITS;

    logic                        clk_in;
    logic                        rst_in;
    logic                        flush_in;
    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_lane_valid;
    logic [WIDTH*PREG_BITS-1:0]  in_src0;
    logic [WIDTH*PREG_BITS-1:0]  in_src1;
    logic [WIDTH*TAG_WIDTH-1:0]  in_tag;
    logic [WIDTH*PREG_BITS-1:0]  rf_rd0_addr;
    logic [WIDTH*PREG_BITS-1:0]  rf_rd1_addr;
    logic [WIDTH*DATA_WIDTH-1:0] rf_rd0_data;
    logic [WIDTH*DATA_WIDTH-1:0] rf_rd1_data;
    logic [WIDTH-1:0]            wb_en;
    logic [WIDTH*PREG_BITS-1:0]  wb_addr;
    logic [WIDTH*DATA_WIDTH-1:0] wb_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_lane_valid;
    logic [WIDTH*DATA_WIDTH-1:0] out_op0;
    logic [WIDTH*DATA_WIDTH-1:0] out_op1;
    logic [WIDTH*TAG_WIDTH-1:0]  out_tag;

    register_read_stage #(
        .WIDTH(WIDTH), .PREG_BITS(PREG_BITS),
        .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
        .in_src0(in_src0), .in_src1(in_src1), .in_tag(in_tag),
        .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
        .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_op0(out_op0),
        .out_op1(out_op1), .out_tag(out_tag)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural register file: combinational reads, written after each edge.
    logic [DATA_WIDTH-1:0] rf_mem [NREGS];
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rf
            assign rf_rd0_data[gi*DATA_WIDTH +: DATA_WIDTH] = rf_mem[rf_rd0_addr[gi*PREG_BITS +: PREG_BITS]];
            assign rf_rd1_data[gi*DATA_WIDTH +: DATA_WIDTH] = rf_mem[rf_rd1_addr[gi*PREG_BITS +: PREG_BITS]];
        end
    endgenerate

    // Reference model of the output bundle.
    logic                        m_valid;
    logic [WIDTH-1:0]            m_lane;
    logic [WIDTH*DATA_WIDTH-1:0] m_op0;
    logic [WIDTH*DATA_WIDTH-1:0] m_op1;
    logic [WIDTH*TAG_WIDTH-1:0]  m_tag;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Value a source register should deliver this cycle.
    function automatic logic [DATA_WIDTH-1:0] model_operand(input logic [PREG_BITS-1:0] src);
        if (src == 0) return '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (wb_en[k] && wb_addr[k*PREG_BITS +: PREG_BITS] == src)
                return wb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        return rf_mem[src];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_lane  = '0;
        m_op0   = '0;
        m_op1   = '0;
        m_tag   = '0;
    endtask

    task automatic idle_inputs();
        flush_in      = 1'b0;
        in_valid      = 1'b0;
        in_lane_valid = '0;
        in_src0       = '0;
        in_src1       = '0;
        in_tag        = '0;
        wb_en         = '0;
        wb_addr       = '0;
        wb_data       = '0;
        out_ready     = 1'b1;
    endtask

    // One clock with the current inputs. The task checks the combinational
    // outputs, advances the model, then compares the registered outputs just after the edge.
    task automatic step();
        logic                        acc;
        logic [WIDTH*DATA_WIDTH-1:0] n_op0, n_op1;
        #2;
        check("in_ready", in_ready, !m_valid || out_ready);
        check("rd0_addr", rf_rd0_addr, in_src0);
        check("rd1_addr", rf_rd1_addr, in_src1);
        acc = in_valid && (!m_valid || out_ready) && !flush_in;
        for (int l = 0; l < WIDTH; l++) begin
            n_op0[l*DATA_WIDTH +: DATA_WIDTH] = model_operand(in_src0[l*PREG_BITS +: PREG_BITS]);
            n_op1[l*DATA_WIDTH +: DATA_WIDTH] = model_operand(in_src1[l*PREG_BITS +: PREG_BITS]);
        end
        @(posedge clk_in);
        #1;
        if (flush_in) begin
            m_valid = 1'b0;
            m_lane  = '0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_lane  = in_lane_valid;
            m_op0   = n_op0;
            m_op1   = n_op1;
            m_tag   = in_tag;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        // The file absorbs writebacks. With duplicate addresses the lowest lane is written last and wins.
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (wb_en[k]) rf_mem[wb_addr[k*PREG_BITS +: PREG_BITS]] = wb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        check("out_valid", out_valid, m_valid);
        check("out_lane_valid", out_lane_valid, m_lane);
        if (m_valid) begin
            check("out_op0", out_op0, m_op0);
            check("out_op1", out_op1, m_op1);
            check("out_tag", out_tag, m_tag);
        end
    endtask

    task automatic random_inputs();
        flush_in      = ($urandom_range(0, 15) == 0);
        in_valid      = ($urandom_range(0, 3) != 0);
        in_lane_valid = WIDTH'($urandom);
        out_ready     = ($urandom_range(0, 3) != 0);
        for (int l = 0; l < WIDTH; l++) begin
            in_src0[l*PREG_BITS +: PREG_BITS] = PREG_BITS'($urandom_range(0, 9));
            in_src1[l*PREG_BITS +: PREG_BITS] = ($urandom_range(0, 3) == 0) ?
                PREG_BITS'($urandom) : PREG_BITS'($urandom_range(0, 9));
            in_tag[l*TAG_WIDTH +: TAG_WIDTH]  = TAG_WIDTH'($urandom);
            wb_en[l]                          = ($urandom_range(0, 1) == 1);
            wb_addr[l*PREG_BITS +: PREG_BITS] = PREG_BITS'($urandom_range(0, 9));
            wb_data[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
        end
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) rf_mem[r] = DATA_WIDTH'($urandom);
        idle_inputs();
        model_reset();
        rst_in = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_lane_valid", out_lane_valid, '0);
        check("rst_op0", out_op0, '0);
        check("rst_op1", out_op1, '0);
        check("rst_tag", out_tag, '0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Single issue from the file
        @(negedge clk_in);
        rf_mem[5] = 32'h11;
        rf_mem[7] = 32'h22;
        in_valid = 1'b1; in_lane_valid = 2'b01;
        in_src0[5:0] = 6'd5; in_src1[5:0] = 6'd7; in_tag[7:0] = 8'h3c;
        step();
        check("issue_op0", out_op0[31:0], 32'h11);
        check("issue_op1", out_op1[31:0], 32'h22);
        check("issue_valid", out_valid, 1'b1);
        check("issue_in_ready", in_ready, 1'b1);

        // Bypass versus the stale file value
        rf_mem[9] = 32'hDEAD;
        in_src0[5:0] = 6'd9;
        wb_en = 2'b10; wb_addr[11:6] = 6'd9; wb_data[63:32] = 32'hBEEF;
        step();
        check("bypass_op0", out_op0[31:0], 32'hBEEF);
        rf_mem[9] = 32'hDEAD;
        wb_en = 2'b00;
        step();
        check("nobypass_op0", out_op0[31:0], 32'hDEAD);

        // Register zero beats a writeback to it and beats the file contents
        rf_mem[0] = 32'h77;
        in_src1[5:0] = 6'd0;
        wb_en = 2'b01; wb_addr[5:0] = 6'd0; wb_data[31:0] = 32'h55;
        step();
        check("zero_op1", out_op1[31:0], 32'h0);
        wb_en = 2'b00;

        // Backpressure: a new bundle waits three cycles, then is accepted once
        in_tag[7:0] = 8'hA5; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_tag_held", out_tag[7:0], 8'h3c);
        end
        out_ready = 1'b1;
        step();
        check("bp_tag_new", out_tag[7:0], 8'hA5);
        in_valid = 1'b0;
        step();
        check("bp_drained", out_valid, 1'b0);

        // Flush while a bundle is held
        in_valid = 1'b1; in_tag[7:0] = 8'h33;
        step();
        out_ready = 1'b0; flush_in = 1'b1; in_tag[7:0] = 8'h44;
        step();
        check("flush_valid", out_valid, 1'b0);
        flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("flush_not_captured", out_valid, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            random_inputs();
            step();
        end

        // Asynchronous reset while a bundle is held
        idle_inputs();
        in_valid = 1'b1; in_lane_valid = 2'b11; in_src0[5:0] = 6'd5; in_tag = 16'hBEAD;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_lane", out_lane_valid, '0);
        check("arst_op0", out_op0, '0);
        check("arst_tag", out_tag, '0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        out_ready = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_read_stage.md
Name: register_read_stage

Overview:
- Consumer end of the physical register file read/write interface.
- Takes an issued bundle of up to WIDTH micro-ops and drives two read requests per lane to the physical register file.
- Bypasses same-cycle writeback data over the file output and registers resolved operands into a one-entry pipeline register feeding execute.
- Sits between issue and execute; valid/ready handshake on both sides; flush support.

Parameters:
- WIDTH, 2, lanes per bundle (matches SUPER_SCALAR_WIDTH).
- PREG_BITS, 6, physical register index width (64 entries).
- DATA_WIDTH, 32, register word width.
- TAG_WIDTH, 8, opaque per-lane micro-op payload passed through.

Ports:
- clk_in  input  1  single clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- flush_in  input  1  squash held and incoming bundle.
- in_valid  input  1  issue bundle valid.
- in_ready  output  1  stage can accept bundle.
- in_lane_valid  input  WIDTH  per-lane occupancy.
- in_src0  input  WIDTH*PREG_BITS  lane source-0 physical register.
- in_src1  input  WIDTH*PREG_BITS  lane source-1 physical register.
- in_tag  input  WIDTH*TAG_WIDTH  pass-through payload.
- rf_rd0_addr  output  WIDTH*PREG_BITS  read port 0 request, per lane.
- rf_rd1_addr  output  WIDTH*PREG_BITS  read port 1 request, per lane.
- rf_rd0_data  input  WIDTH*DATA_WIDTH  file response, combinational, same cycle.
- rf_rd1_data  input  WIDTH*DATA_WIDTH  file response, combinational, same cycle.
- wb_en  input  WIDTH  writeback write enables (same signals the file sees).
- wb_addr  input  WIDTH*PREG_BITS  writeback destinations.
- wb_data  input  WIDTH*DATA_WIDTH  writeback data.
- out_valid  output  1  operand bundle valid.
- out_ready  input  1  execute accepts bundle.
- out_lane_valid  output  WIDTH  registered lane mask.
- out_op0  output  WIDTH*DATA_WIDTH  resolved source-0 operand.
- out_op1  output  WIDTH*DATA_WIDTH  resolved source-1 operand.
- out_tag  output  WIDTH*TAG_WIDTH  registered payload.

Behaviour:
- Reset (rst_in low, asynchronous): out_valid=0, out_lane_valid=0, out_op0/out_op1/out_tag=0. After release, in_ready=1 on the first edge.
- Read address outputs are combinational copies of in_src0/in_src1 every cycle, regardless of in_valid.
- in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer.
- Accept when in_valid && in_ready && !flush_in. At that edge the output register loads lanes, operands and tags, and out_valid becomes 1. Latency issue→out_valid is 1 cycle.
- If out_valid && out_ready && no accept, out_valid clears.
- Operand resolution, per lane L, per source s:
  - If src == 0, the operand is 0. This priority is highest.
  - Else, the operand is wb_data[k] of the lowest-index write lane k with wb_en[k] && wb_addr[k]==src.
  - Else, the operand is rf_rd data. The file updates at the edge, so its same-cycle read is stale; this makes the bypass mandatory.
- Lanes with in_lane_valid=0 still load data (don't-care); out_lane_valid carries the mask unchanged.
- Held bundle (out_valid && !out_ready): all outputs stable; no re-resolution; in_ready=0.
- flush_in=1: at the edge, out_valid=0 and out_lane_valid=0 regardless of out_ready; the incoming bundle is dropped. in_ready is unaffected by flush.
- Duplicate wb_addr across enabled write lanes is illegal upstream; the lowest lane wins deterministically.
- Reset asserted mid-transfer: outputs clear immediately; the bundle is lost.

Test Plan:
- Reset then single issue: lane0 src0=5, src1=7; file returns 0x11/0x22; no wb → next cycle out_valid=1, out_op0[0]=0x11, out_op1[0]=0x22, in_ready=1 with out_ready=1.
- Bypass: src0=9, file returns 0xDEAD, same cycle wb_en[1]=1, wb_addr[1]=9, wb_data[1]=0xBEEF → out_op0=0xBEEF. Repeat with wb_en=0 → 0xDEAD.
- Zero register: src1=0 with wb_en[0]=1, wb_addr[0]=0, wb_data[0]=0x55 → out_op1=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and a new bundle → in_ready=0, outputs unchanged. The out_ready=1 cycle sets in_ready=1 and accepts the new bundle; exactly 2 bundles reach the output, none duplicated.
- Flush while holding: out_valid=1, out_ready=0, flush_in=1 with in_valid=1 → next cycle out_valid=0, new bundle not captured.
- Asynchronous reset mid-hold: drop rst_in between edges → out_valid=0 before the next clock edge, outputs zero.
